// File: rtl/float_to_int_pkg.sv
// Shared types and constants for the float_to_int converter.
// Optional single-cycle shifter: define FLOAT_TO_INT_BARREL_EN.
package float_to_int_pkg;

    localparam int unsigned W_INT     = 32;
    localparam int unsigned EXP_W     = 10;
    localparam int signed   BIAS      = 127;
    localparam logic [31:0] SAT_VALUE = 32'h8000_0000;

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        SPECIAL,
        SHIFT,
        PACK,
        PUT_Z
    } state_e;

endpackage

// File: rtl/float_to_int_shift.sv
// Right-shift datapath aligning the mantissa to an integer.
// FLOAT_TO_INT_BARREL_EN selects a one-cycle barrel shift; default is one bit per cycle.
module float_to_int_shift
    import float_to_int_pkg::*;
(
    input  logic [W_INT-1:0]        m,
    input  logic signed [EXP_W-1:0] e,
    output logic [W_INT-1:0]        m_next,
    output logic signed [EXP_W-1:0] e_next,
    output logic                    done
);

`ifdef FLOAT_TO_INT_BARREL_EN
    // e is 0..30 here, so 31-e fits in five bits.
    logic [4:0] amt;

    always_comb begin
        amt    = 5'd31 - e[4:0];
        m_next = m >> amt;
        e_next = e;
        done   = 1'b1;
    end
`else
    localparam logic signed [EXP_W-1:0] LastExp = EXP_W'(31);

    always_comb begin
        done   = !(e < LastExp);
        m_next = m;
        e_next = e;
        if (!done) begin
            m_next = m >> 1;
            e_next = e + EXP_W'(1);
        end
    end
`endif

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero, stb/ack handshake.
// FLOAT_TO_INT_BARREL_EN fixes the normal-path latency at 4 cycles.
module float_to_int
    import float_to_int_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_e                  state_q, state_d;
    logic [31:0]             a_q, a_d;
    logic                    s_q, s_d;
    logic signed [EXP_W-1:0] e_q, e_d;
    logic [W_INT-1:0]        m_q, m_d;
    logic [31:0]             z_q, z_d;
    logic                    z_stb_q, z_stb_d;
    logic                    a_ack_q, a_ack_d;

    logic [W_INT-1:0]        sh_m;
    logic signed [EXP_W-1:0] sh_e;
    logic                    sh_done;

    float_to_int_shift u_shift (
        .m      (m_q),
        .e      (e_q),
        .m_next (sh_m),
        .e_next (sh_e),
        .done   (sh_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            s_q     <= 1'b0;
            e_q     <= '0;
            m_q     <= '0;
            z_q     <= '0;
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            z_q     <= z_d;
            z_stb_q <= z_stb_d;
            a_ack_q <= a_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        z_d     = z_q;
        z_stb_d = z_stb_q;
        a_ack_d = a_ack_q;

        unique case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                s_d     = a_q[31];
                e_d     = $signed({2'b00, a_q[30:23]}) - EXP_W'(BIAS);
                m_d     = {1'b1, a_q[22:0], 8'b0};
                state_d = SPECIAL;
            end
            SPECIAL: begin
                // Below 1.0 truncates to zero; 2^31 and above (incl. inf/NaN) saturate.
                if (e_q < 0) begin
                    z_d     = '0;
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else if (e_q > 30) begin
                    z_d     = SAT_VALUE;
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                m_d = sh_m;
                e_d = sh_e;
                if (sh_done) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                z_d     = s_q ? -m_q : m_q;
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    assign input_a_ack  = a_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed self-checking bench for float_to_int (both shifter builds).
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    float_to_int dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    localparam int NVec = 15;
    // Operand, expected result, special-path flag, iterative latency (35-e).
    logic [31:0] vec_a [NVec] = '{
        32'h3F80_0000, 32'hC020_0000, 32'h3F40_0000, 32'h8000_0000, 32'h4E80_0000,
        32'h4F00_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h42F6_0000, 32'hBF80_0000,
        32'h3FFF_FFFF, 32'hCF00_0000, 32'h7F7F_FFFF, 32'h0000_0001, 32'hCE80_0001};
    logic [31:0] vec_z [NVec] = '{
        32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000,
        32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_007B, 32'hFFFF_FFFF,
        32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hBFFF_FF80};
    bit vec_sp [NVec] = '{0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int vec_li [NVec] = '{35, 34, 2, 2, 5, 2, 2, 2, 29, 35, 35, 2, 2, 2, 5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input bit special, input int lat_iter);
        if (special) return 2;
`ifdef FLOAT_TO_INT_BARREL_EN
        return 4;
`else
        return lat_iter;
`endif
    endfunction

    // Returns just after the accept edge.
    task automatic send(input logic [31:0] a);
        int cyc = 0;
        while (!input_a_ack && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!input_a_ack) check("ack_timeout", {31'b0, input_a_ack}, 32'd1);
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        check("ack_drop", {31'b0, input_a_ack}, 32'd0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!output_z_stb && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!output_z_stb) check("stb_timeout", {31'b0, output_z_stb}, 32'd1);
    endtask

    initial begin
        int lat;
        rst          = 1'b0;
        input_a      = '0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, input_a_ack}, 32'd0);
        check("rst_stb", {31'b0, output_z_stb}, 32'd0);
        check("rst_z", output_z, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < NVec; i++) begin
            send(vec_a[i]);
            wait_result(lat);
            check($sformatf("z[%0d]", i), output_z, vec_z[i]);
            check($sformatf("lat[%0d]", i), lat, exp_lat(vec_sp[i], vec_li[i]));
        end

        // Back-pressure: result and stb must hold, no new operand acked.
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        send(32'hC020_0000);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_z", output_z, 32'hFFFF_FFFE);
            check("bp_stb", {31'b0, output_z_stb}, 32'd1);
            check("bp_ack", {31'b0, input_a_ack}, 32'd0);
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {31'b0, output_z_stb}, 32'd0);
        send(32'h3F80_0000);
        wait_result(lat);
        check("bp_next_z", output_z, 32'd1);

        // Reset while the converter is in SHIFT.
        @(posedge clk); #1;
        send(32'h3F80_0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mid_rst_ack", {31'b0, input_a_ack}, 32'd0);
        check("mid_rst_stb", {31'b0, output_z_stb}, 32'd0);
        check("mid_rst_z", output_z, 32'd0);
        send(32'h4120_0000);
        wait_result(lat);
        check("post_rst_z", output_z, 32'd10);
        check("post_rst_lat", lat, exp_lat(1'b0, 32));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Handshaked multi-cycle converter from IEEE-754 single precision to signed 32-bit integer.
- Truncates toward zero.
- Reverse-direction partner of the team's int_to_float. Sits in the same stim-file test harness as the other math components.
- Uses the team's stb/ack stream handshake on input and output.

Parameters:
- W_INT, 32: integer result width; fixed at 32 for this release.
- BIAS, 127: IEEE single exponent bias.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low.
- input_a  input  32  IEEE-754 single operand.
- input_a_stb  input  1  operand valid.
- input_a_ack  output  1  operand accepted; registered.
- output_z  output  32  two's-complement result; registered.
- output_z_stb  output  1  result valid; registered.
- output_z_ack  input  1  consumer takes result.

Behaviour:
- Reset (rst==0 at clk edge): state=GET_A, input_a_ack=0, output_z_stb=0, output_z=0. Reset wins over every other event, including mid-SHIFT or PUT_Z. Any in-flight operand is discarded.
- Internal registers: s (1 bit), e (signed 10 bit), m (32 bit).
- GET_A: input_a_ack<=1. If input_a_ack && input_a_stb: latch a, input_a_ack<=0, go to UNPACK. At most one transfer per ack pulse.
- UNPACK: s=a[31], e=a[30:23]-BIAS, m={1'b1,a[22:23-23],8'b0} (i.e. hidden 1, 23-bit fraction, 8 zero bits). Go to SPECIAL.
- SPECIAL, evaluated in priority order:
  - e<0: covers zero, denormals and |x|<1. output_z<=0, output_z_stb<=1, go to PUT_Z.
  - e>30: covers inf, NaN and |x|>=2^31. output_z<=32'h80000000, output_z_stb<=1, go to PUT_Z. The exact value -2^31 also maps here and is correct.
  - Otherwise go to SHIFT.
- SHIFT: if e<31 then m<=m>>1, e<=e+1; else go to PACK. Shifted-out bits are dropped, which gives the truncation.
- PACK: output_z<=s ? -m : m, output_z_stb<=1, go to PUT_Z.
- PUT_Z: output_z and output_z_stb are held stable until output_z_ack. On output_z_stb && output_z_ack: output_z_stb<=0, go to GET_A.
- No overlap: a new operand is not acked until the result has been taken.
- Latency, counted from the accept edge to the edge that raises output_z_stb:
  - Special path: 2 cycles.
  - Normal path: 35-e cycles, ranging from 5 (e=30) to 35 (e=0).
- output_z_ack while output_z_stb==0 is ignored. input_a_stb outside GET_A is ignored.

Optional Feature:
- FLOAT_TO_INT_BARREL_EN defined:
  - SHIFT completes in one cycle: m<=m>>(31-e), then go to PACK.
  - Normal-path latency is fixed at 4 cycles.
- Undefined: iterative one-bit-per-cycle shifter as above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package/include float_to_int_pkg holds:
  - state encodings GET_A, UNPACK, SPECIAL, SHIFT, PACK, PUT_Z;
  - BIAS;
  - SAT_VALUE=32'h80000000;
  - exponent width 10.
- One sub-module, float_to_int_shift, holds the right-shift datapath: iterative step or barrel, selected by the macro.
- FSM and handshake stay in the top level.

Test Plan:
- 0x3F800000 (1.0), output_z_ack held high → output_z=1. output_z_stb rises 35 cycles after accept (4 with macro).
- 0xC0200000 (-2.5) → 0xFFFFFFFE. 0x3F400000 (0.75) → 0 after 2 cycles. 0x80000000 (-0.0) → 0.
- 0x4E800000 (2^30) → 0x40000000. 0x4F000000 (2^31) → 0x80000000. 0x7FC00000 (NaN) and 0xFF800000 (-inf) → 0x80000000.
- Back-pressure: output_z_ack low for 10 cycles after output_z_stb rises → output_z and output_z_stb unchanged, input_a_ack stays 0. Ack then → next operand accepted.
- rst=0 for one cycle mid-SHIFT → next cycle input_a_ack=0, output_z_stb=0, output_z=0. New operand 0x41200000 (10.0) → 10.
- Stim-file soak: 5000 random floats from stim/float_to_int_a vs golden stim/float_to_int_z, both macro settings → zero mismatches.
